// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture block: input format codes,
// capture FSM encoding and a few RGB332 reference colours.
package ov7670_capture_pkg;

  localparam logic [1:0] FMT_RGB565 = 2'd0;
  localparam logic [1:0] FMT_RGB555 = 2'd1;
  localparam logic [1:0] FMT_RGB444 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_FRAME   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] RGB332_RED   = 8'hE0;
  localparam logic [7:0] RGB332_GREEN = 8'h1C;
  localparam logic [7:0] RGB332_BLUE  = 8'h03;

endpackage

// File: rtl/rgb_to_rgb332.sv
// Combinational repack of one camera pixel (two bytes) into RGB332.
// The two LSBs of the second byte never reach the output, so they are not ported.
module rgb_to_rgb332
  import ov7670_capture_pkg::*;
(
  input  logic [7:0] hi_i,
  input  logic [7:2] lo_i,
  input  logic [1:0] fmt_i,
  output logic [7:0] rgb_o
);

  function automatic logic [7:0] pack332(input logic [7:0] hi, input logic [7:2] lo,
                                         input logic [1:0] fmt);
    case (fmt)
      FMT_RGB555: return {hi[6:4], hi[1:0], lo[7], lo[4:3]};
      FMT_RGB444: return {hi[3:1], lo[7:5], lo[3:2]};
      default:    return {hi[7:5], hi[2:0], lo[4:3]};
    endcase
  endfunction

  assign rgb_o = pack332(hi_i, lo_i, fmt_i);

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 byte-stream capture: pairs bytes into pixels, decimates/clips to the
// stored image size and emits a linear frame-buffer write port plus frame stats.
module ov7670_frame_capture
  import ov7670_capture_pkg::*;
#(
  parameter int IMG_WIDTH  = 176,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_W     = 15,
  parameter int DECIM_X    = 1,
  parameter int DECIM_Y    = 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [7:0]        CAM_DATA,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [1:0]        IN_FMT,
  input  logic              CONTINUOUS,
  input  logic              ARM,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              FRAME_DONE,
  output logic              BUSY,
  output logic [ADDR_W:0]   FRAME_PIXELS,
  output logic [7:0]        FRAME_CNT,
  output logic              ERR_ODD_LINE
);

  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam logic [COL_W-1:0]  WIDTH_C  = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0]  HEIGHT_C = ROW_W'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH);
  localparam logic [3:0]        XLAST    = 4'(DECIM_X - 1);
  localparam logic [3:0]        YLAST    = 4'(DECIM_Y - 1);

  state_t            state_q;
  logic [7:0]        data_p0_q, hi_q;
  logic              href_p0_q, vsync_p0_q, href_p1_q, vsync_p1_q;
  logic              phase_q;
  logic [1:0]        fmt_q;
  logic [3:0]        xcnt_q, ycnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q, wr_addr_q;
  logic [ADDR_W:0]   pix_cnt_q, frame_pix_q;
  logic              wr_en_q, done_q, busy_q, err_q;
  logic [7:0]        wr_data_q, frame_cnt_q;
  logic [7:0]        rgb_d;

  logic vs_fall, vs_rise, href_fall, keep_px;
  assign vs_fall   = vsync_p1_q & ~vsync_p0_q;
  assign vs_rise   = ~vsync_p1_q & vsync_p0_q;
  assign href_fall = href_p1_q & ~href_p0_q;
  assign keep_px   = (xcnt_q == '0) && (ycnt_q == '0) && (col_q < WIDTH_C) && (row_q < HEIGHT_C);

  // Stage p0: pin capture; the high byte is held once the phase flips to LO.
  always_ff @(posedge CLOCK) begin
    data_p0_q <= CAM_DATA;
    if (!phase_q) hi_q <= data_p0_q;
  end

  rgb_to_rgb332 u_conv (
    .hi_i  (hi_q),
    .lo_i  (data_p0_q[7:2]),
    .fmt_i (fmt_q),
    .rgb_o (rgb_d)
  );

  // Stage p1: frame FSM, pairing, decimation and the registered write port.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_WAIT_VS;
      href_p0_q   <= 1'b0;
      vsync_p0_q  <= 1'b0;
      href_p1_q   <= 1'b0;
      vsync_p1_q  <= 1'b0;
      phase_q     <= 1'b0;
      fmt_q       <= FMT_RGB565;
      xcnt_q      <= '0;
      ycnt_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      pix_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_pix_q <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      href_p0_q  <= CAM_HREF;
      vsync_p0_q <= CAM_VSYNC;
      href_p1_q  <= href_p0_q;
      vsync_p1_q <= vsync_p0_q;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      if (ARM && !busy_q) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ARM || CONTINUOUS) state_q <= S_WAIT_VS;
        end
        S_WAIT_VS: begin
          if (vs_fall) begin
            state_q   <= S_FRAME;
            busy_q    <= 1'b1;
            fmt_q     <= IN_FMT;
            phase_q   <= 1'b0;
            xcnt_q    <= '0;
            ycnt_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            pix_cnt_q <= '0;
          end
        end
        S_FRAME: begin
          if (vs_rise) begin
            if (phase_q) err_q <= 1'b1;
            phase_q     <= 1'b0;
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            frame_pix_q <= pix_cnt_q;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end else if (href_fall) begin
            if (phase_q) err_q <= 1'b1;
            phase_q <= 1'b0;
            xcnt_q  <= '0;
            col_q   <= '0;
            ycnt_q  <= (ycnt_q == YLAST) ? 4'd0 : ycnt_q + 4'd1;
            if ((ycnt_q == '0) && (row_q < HEIGHT_C)) begin
              row_q  <= row_q + 1'b1;
              base_q <= base_q + ROW_STEP;
            end
          end else if (href_p0_q) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
              xcnt_q <= (xcnt_q == XLAST) ? 4'd0 : xcnt_q + 4'd1;
              if (keep_px) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= base_q + ADDR_W'(col_q);
                wr_data_q <= rgb_d;
                col_q     <= col_q + 1'b1;
                pix_cnt_q <= pix_cnt_q + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= CONTINUOUS ? S_WAIT_VS : S_IDLE;
        end
        default: state_q <= S_WAIT_VS;
      endcase
    end
  end

  assign WR_EN        = wr_en_q;
  assign WR_ADDR      = wr_addr_q;
  assign WR_DATA      = wr_data_q;
  assign FRAME_DONE   = done_q;
  assign BUSY         = busy_q;
  assign FRAME_PIXELS = frame_pix_q;
  assign FRAME_CNT    = frame_cnt_q;
  assign ERR_ODD_LINE = err_q;

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench for ov7670_frame_capture: a full-size instance and a small
// 2x-decimating instance share one camera bus; writes are logged at negedge.
`timescale 1ns/1ps
module tb_ov7670_frame_capture;
  import ov7670_capture_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cam_href, cam_vsync, continuous, arm;
  logic [7:0] cam_data;
  logic [1:0] in_fmt;

  logic        wr_en0, done0, busy0, err0;
  logic [14:0] wr_addr0;
  logic [7:0]  wr_data0, fcnt0;
  logic [15:0] fpix0;

  logic        wr_en1, done1, busy1, err1;
  logic [3:0]  wr_addr1;
  logic [7:0]  wr_data1, fcnt1;
  logic [4:0]  fpix1;

  ov7670_frame_capture dut0 (
    .CLOCK(clk), .RESET_N(rst_n), .CAM_DATA(cam_data), .CAM_HREF(cam_href),
    .CAM_VSYNC(cam_vsync), .IN_FMT(in_fmt), .CONTINUOUS(continuous), .ARM(arm),
    .WR_EN(wr_en0), .WR_ADDR(wr_addr0), .WR_DATA(wr_data0), .FRAME_DONE(done0),
    .BUSY(busy0), .FRAME_PIXELS(fpix0), .FRAME_CNT(fcnt0), .ERR_ODD_LINE(err0)
  );

  ov7670_frame_capture #(
    .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_W(4), .DECIM_X(2), .DECIM_Y(2)
  ) dut1 (
    .CLOCK(clk), .RESET_N(rst_n), .CAM_DATA(cam_data), .CAM_HREF(cam_href),
    .CAM_VSYNC(cam_vsync), .IN_FMT(in_fmt), .CONTINUOUS(continuous), .ARM(arm),
    .WR_EN(wr_en1), .WR_ADDR(wr_addr1), .WR_DATA(wr_data1), .FRAME_DONE(done1),
    .BUSY(busy1), .FRAME_PIXELS(fpix1), .FRAME_CNT(fcnt1), .ERR_ODD_LINE(err1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] a0_q[$], a1_q[$];
  logic [7:0]  d0_q[$], d1_q[$];
  int          done0_n = 0, done1_n = 0;

  always @(negedge clk) begin
    if (wr_en0) begin a0_q.push_back(16'(wr_addr0)); d0_q.push_back(wr_data0); end
    if (wr_en1) begin a1_q.push_back(16'(wr_addr1)); d1_q.push_back(wr_data1); end
    if (done0) done0_n++;
    if (done1) done1_n++;
  end

  function automatic logic [15:0] a0_at(input int i);
    return (i < a0_q.size()) ? a0_q[i] : 16'hxxxx;
  endfunction
  function automatic logic [7:0] d0_at(input int i);
    return (i < d0_q.size()) ? d0_q[i] : 8'hxx;
  endfunction
  function automatic logic [15:0] a1_at(input int i);
    return (i < a1_q.size()) ? a1_q[i] : 16'hxxxx;
  endfunction
  function automatic logic [7:0] d1_at(input int i);
    return (i < d1_q.size()) ? d1_q[i] : 8'hxx;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic put(input logic [7:0] b, input logic h);
    @(negedge clk);
    cam_data = b;
    cam_href = h;
  endtask
  task automatic pix(input logic [7:0] b1, input logic [7:0] b2);
    put(b1, 1'b1);
    put(b2, 1'b1);
  endtask
  task automatic line_end();
    put(8'h00, 1'b0);
    cyc(3);
  endtask
  task automatic uniform_line(input int n, input logic [7:0] b1, input logic [7:0] b2);
    repeat (n) pix(b1, b2);
    line_end();
  endtask
  task automatic frame_start();
    @(negedge clk) cam_vsync = 1'b1;
    cyc(3);
    @(negedge clk) cam_vsync = 1'b0;
    cyc(3);
  endtask
  task automatic frame_end();
    @(negedge clk) cam_vsync = 1'b1;
    cyc(4);
  endtask
  task automatic arm_pulse();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
  endtask
  task automatic small_frame();
    frame_start();
    repeat (2) uniform_line(3, 8'hF8, 8'h00);
    frame_end();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int m0, m1, dm0, dm1, n, bad_a, bad_d;
    rst_n = 1'b0; cam_data = 8'h00; cam_href = 1'b0; cam_vsync = 1'b0;
    in_fmt = FMT_RGB565; continuous = 1'b1; arm = 1'b0;
    cyc(3);
    check_val("por_outputs", 64'({wr_en0, wr_addr0, wr_data0, done0, busy0, fpix0, fcnt0, err0}), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(2);

    // Reset asserted in the middle of a line.
    frame_start();
    repeat (2) uniform_line(4, 8'hF8, 8'h00);
    pix(8'hF8, 8'h00);
    pix(8'hF8, 8'h00);
    check_val("busy_before_reset", 64'(busy0), 1);
    @(negedge clk) begin rst_n = 1'b0; cam_data = 8'hF8; end
    cyc(1);
    check_val("reset_outputs", 64'({wr_en0, wr_addr0, wr_data0, done0, busy0, fpix0, fcnt0, err0}), 0);
    cyc(1);
    @(negedge clk) rst_n = 1'b1;
    m0 = a0_q.size(); dm0 = done0_n;
    pix(8'hF8, 8'h00);
    line_end();
    repeat (2) uniform_line(4, 8'hF8, 8'h00);
    frame_end();
    check_val("no_wr_after_reset", 64'(a0_q.size() - m0), 0);
    check_val("no_done_after_reset", 64'(done0_n - dm0), 0);

    // Full RGB565 frame, one extra pixel per line and one extra line to exercise clipping.
    m0 = a0_q.size(); dm0 = done0_n;
    frame_start();
    repeat (121) uniform_line(177, 8'hF8, 8'h00);
    frame_end();
    n = a0_q.size() - m0;
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < n; i++) begin
      if (a0_q[m0 + i] != 16'(i)) bad_a++;
      if (d0_q[m0 + i] != RGB332_RED) bad_d++;
    end
    check_val("t2_wr_count", 64'(n), 21120);
    check_val("t2_addr_seq_errs", 64'(bad_a), 0);
    check_val("t2_data_errs", 64'(bad_d), 0);
    check_val("t2_last_addr", 64'(a0_at(a0_q.size() - 1)), 21119);
    check_val("t2_done_pulses", 64'(done0_n - dm0), 1);
    check_val("t2_frame_pixels", 64'(fpix0), 21120);
    check_val("t2_frame_cnt", 64'(fcnt0), 1);
    check_val("t2_busy_after", 64'(busy0), 0);

    // Format conversion; IN_FMT changed mid-frame must not take effect.
    m0 = a0_q.size();
    in_fmt = FMT_RGB565;
    frame_start();
    pix(8'h07, 8'hE0);
    in_fmt = FMT_RGB444;
    pix(8'h07, 8'hE0);
    line_end();
    frame_end();
    check_val("fmt565", 64'(d0_at(m0)), 'h1C);
    check_val("fmt_locked_at_start", 64'(d0_at(m0 + 1)), 'h1C);
    m0 = a0_q.size();
    in_fmt = FMT_RGB555;
    frame_start(); pix(8'h00, 8'h1F); line_end(); frame_end();
    check_val("fmt555", 64'(d0_at(m0)), 'h03);
    m0 = a0_q.size();
    in_fmt = FMT_RGB444;
    frame_start(); pix(8'h0F, 8'h00); line_end(); frame_end();
    check_val("fmt444", 64'(d0_at(m0)), 'hE0);
    m0 = a0_q.size();
    in_fmt = 2'd3;
    frame_start(); pix(8'h07, 8'hE0); line_end(); frame_end();
    check_val("fmt_reserved_as_565", 64'(d0_at(m0)), 'h1C);
    check_val("t3_frame_cnt", 64'(fcnt0), 5);

    // 2x2 decimation on the small instance: 10x8 input into a 4x3 store.
    in_fmt = FMT_RGB565;
    m1 = a1_q.size(); dm1 = done1_n;
    frame_start();
    for (int ln = 0; ln < 8; ln++) begin
      for (int px = 0; px < 10; px++) pix({3'(px), 2'b00, 3'(ln)}, 8'h00);
      line_end();
    end
    frame_end();
    n = a1_q.size() - m1;
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < n; i++) begin
      if (a1_q[m1 + i] != 16'(i)) bad_a++;
      if (d1_q[m1 + i] != {3'(2 * (i % 4)), 3'(2 * (i / 4)), 2'b00}) bad_d++;
    end
    check_val("t4_wr_count", 64'(n), 12);
    check_val("t4_addr_seq_errs", 64'(bad_a), 0);
    check_val("t4_data_errs", 64'(bad_d), 0);
    check_val("t4_px2_addr", 64'(a1_at(m1 + 1)), 1);
    check_val("t4_px2_data", 64'(d1_at(m1 + 1)), 'h40);
    check_val("t4_line2_addr", 64'(a1_at(m1 + 4)), 4);
    check_val("t4_line2_data", 64'(d1_at(m1 + 4)), 'h08);
    check_val("t4_frame_pixels", 64'(fpix1), 12);
    check_val("t4_done_pulses", 64'(done1_n - dm1), 1);

    // Odd-length line: partial pixel dropped, sticky error, ARM clears it.
    check_val("t5_err_initially_clear", 64'(err0), 0);
    m0 = a0_q.size();
    frame_start();
    put(8'hF8, 1'b1); put(8'h00, 1'b1); put(8'hF8, 1'b1); put(8'h00, 1'b1); put(8'hF8, 1'b1);
    line_end();
    check_val("t5_err_set", 64'(err0), 1);
    repeat (2) pix(8'h07, 8'hE0);
    line_end();
    check_val("t5_err_sticky", 64'(err0), 1);
    frame_end();
    check_val("t5_wr_count", 64'(a0_q.size() - m0), 4);
    check_val("t5_second_px_addr", 64'(a0_at(m0 + 1)), 1);
    check_val("t5_line1_addr", 64'(a0_at(m0 + 2)), 176);
    check_val("t5_line1_data", 64'(d0_at(m0 + 2)), 'h1C);
    check_val("t5_frame_pixels", 64'(fpix0), 4);
    check_val("t5_err_after_frame", 64'(err0), 1);
    arm_pulse();
    cyc(1);
    check_val("t5_arm_clears_err", 64'(err0), 0);

    // CONTINUOUS dropped mid-frame: this frame completes, then idle.
    m0 = a0_q.size(); dm0 = done0_n;
    frame_start();
    uniform_line(3, 8'hF8, 8'h00);
    continuous = 1'b0;
    uniform_line(3, 8'hF8, 8'h00);
    frame_end();
    check_val("t6_drop_cont_writes", 64'(a0_q.size() - m0), 6);
    check_val("t6_drop_cont_done", 64'(done0_n - dm0), 1);
    check_val("t6_idle_not_busy", 64'(busy0), 0);
    m0 = a0_q.size(); dm0 = done0_n;
    small_frame();
    check_val("t6_idle_no_wr", 64'(a0_q.size() - m0), 0);
    check_val("t6_idle_no_done", 64'(done0_n - dm0), 0);

    // ARM mid-frame waits for the next frame start.
    m0 = a0_q.size();
    frame_start();
    uniform_line(3, 8'hF8, 8'h00);
    arm_pulse();
    uniform_line(3, 8'hF8, 8'h00);
    check_val("t6_arm_midframe_no_wr", 64'(a0_q.size() - m0), 0);
    check_val("t6_arm_midframe_not_busy", 64'(busy0), 0);
    frame_end();
    m0 = a0_q.size(); dm0 = done0_n;
    frame_start();
    check_val("t6_armed_frame_busy", 64'(busy0), 1);
    uniform_line(3, 8'hF8, 8'h00);
    arm_pulse();
    uniform_line(3, 8'hF8, 8'h00);
    frame_end();
    check_val("t6_armed_frame_writes", 64'(a0_q.size() - m0), 6);
    check_val("t6_armed_frame_done", 64'(done0_n - dm0), 1);
    check_val("t6_armed_frame_busy_after", 64'(busy0), 0);
    m0 = a0_q.size(); dm0 = done0_n;
    small_frame();
    check_val("t6_after_shot_no_wr", 64'(a0_q.size() - m0), 0);
    check_val("t6_after_shot_no_done", 64'(done0_n - dm0), 0);
    check_val("frame_cnt_final", 64'(fcnt0), 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
